// File: rtl/load_store_unit.sv
// Load/store unit: aligns CPU loads and stores onto a 32-bit word bus with
// request/grant address phase and a single rvalid response per grant.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_en_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  lsu_done_o,
  output logic                  lsu_err_o,
  output logic [31:0]           rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sext;
  logic [31:0]           r_wdata;

  logic                  w_misaligned;
  logic                  w_issue;
  logic                  w_in_idle;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_we;
  logic [1:0]            w_sel_size;
  logic [31:0]           w_sel_wdata;
  logic [1:0]            w_sel_off;
  logic [31:0]           w_shifted;

  // Alignment check on the live request inputs.
  always_comb begin
    w_misaligned = 1'b0;
    case (size_i)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = addr_i[0];
      2'b10:   w_misaligned = (addr_i[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  assign w_in_idle = (r_state == IDLE);
  assign w_issue   = rst_n && w_in_idle && lsu_en_i && !w_misaligned;

  // In IDLE the request is driven straight from the inputs so it can go out
  // in the issue cycle; afterwards the latched copy keeps the bus stable.
  assign w_sel_addr  = w_in_idle ? addr_i  : r_addr;
  assign w_sel_we    = w_in_idle ? we_i    : r_we;
  assign w_sel_size  = w_in_idle ? size_i  : r_size;
  assign w_sel_wdata = w_in_idle ? wdata_i : r_wdata;
  assign w_sel_off   = w_sel_addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Capture the request fields when an aligned access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_sext  <= 1'b0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_addr  <= addr_i;
      r_we    <= we_i;
      r_size  <= size_i;
      r_sext  <= sign_ext_i;
      r_wdata <= wdata_i;
    end
  end

  // Next-state and handshake outputs; all forced low while in reset.
  always_comb begin
    w_next     = r_state;
    data_req_o = 1'b0;
    lsu_done_o = 1'b0;
    lsu_err_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (lsu_en_i) begin
          if (w_misaligned) begin
            lsu_err_o = 1'b1;
          end else begin
            data_req_o = 1'b1;
            w_next     = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) w_next = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          lsu_done_o = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (!rst_n) begin
      data_req_o = 1'b0;
      lsu_done_o = 1'b0;
      lsu_err_o  = 1'b0;
    end
  end

  assign data_addr_o = {w_sel_addr[ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o   = w_sel_we;

  // Byte enables and lane-replicated write data.
  always_comb begin
    data_be_o    = '0;
    data_wdata_o = w_sel_wdata;
    case (w_sel_size)
      2'b00: begin
        data_be_o    = 4'b0001 << w_sel_off;
        data_wdata_o = {4{w_sel_wdata[7:0]}};
      end
      2'b01: begin
        data_be_o    = w_sel_off[1] ? 4'b1100 : 4'b0011;
        data_wdata_o = {2{w_sel_wdata[15:0]}};
      end
      2'b10:   data_be_o = 4'b1111;
      default: data_be_o = '0;
    endcase
  end

  assign w_shifted = data_rdata_i >> {r_addr[1:0], 3'b000};

  // Load data formatting, zero except in the done cycle.
  always_comb begin
    rdata_o = '0;
    if (lsu_done_o) begin
      case (r_size)
        2'b00:   rdata_o = {{24{r_sext & w_shifted[7]}},  w_shifted[7:0]};
        2'b01:   rdata_o = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
        default: rdata_o = data_rdata_i;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        lsu_en_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        lsu_done_o;
  logic        lsu_err_o;
  logic [31:0] rdata_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int checks;
  int failures;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu_en_i     (lsu_en_i),
    .we_i         (we_i),
    .size_i       (size_i),
    .sign_ext_i   (sign_ext_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .lsu_done_o   (lsu_done_o),
    .lsu_err_o    (lsu_err_o),
    .rdata_o      (rdata_o),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic en, input logic we, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a, input logic [31:0] wd);
    lsu_en_i = en; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
  endtask

  task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
    data_gnt_i = g; data_rvalid_i = rv; data_rdata_i = rd;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus(1'b0, 1'b0, 32'h0);

    // Reset state, with a request pending on the inputs.
    step(); lsu_en_i = 1'b1; #1;
    check("rst_req",  {31'b0, data_req_o}, 32'd0);
    check("rst_done", {31'b0, lsu_done_o}, 32'd0);
    check("rst_err",  {31'b0, lsu_err_o},  32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    step(); lsu_en_i = 1'b0; rst_n = 1'b1;

    // Signed byte load at 0x103, grant at issue.
    step(); req(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0); bus(1'b1, 1'b0, 32'h0); #1;
    check("sb_req",  {31'b0, data_req_o}, 32'd1);
    check("sb_be",   {28'b0, data_be_o},  32'h8);
    check("sb_addr", data_addr_o, 32'h100);
    check("sb_we",   {31'b0, data_we_o},  32'd0);
    check("sb_done_issue", {31'b0, lsu_done_o}, 32'd0);
    step(); bus(1'b0, 1'b1, 32'h80FFFFFF); #1;
    check("sb_done", {31'b0, lsu_done_o}, 32'd1);
    check("sb_rdata", rdata_o, 32'hFFFFFF80);
    check("sb_req_wait", {31'b0, data_req_o}, 32'd0);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0); #1;
    check("sb_done_after", {31'b0, lsu_done_o}, 32'd0);
    check("sb_rdata_after", rdata_o, 32'h0);

    // Zero-extended half load at 0x202.
    step(); req(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0); bus(1'b1, 1'b0, 32'h0); #1;
    check("lh_be",   {28'b0, data_be_o}, 32'hC);
    check("lh_addr", data_addr_o, 32'h200);
    step(); bus(1'b0, 1'b1, 32'hBEEF1234); #1;
    check("lh_done",  {31'b0, lsu_done_o}, 32'd1);
    check("lh_rdata", rdata_o, 32'h0000BEEF);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0);

    // Signed byte load at offset 1, positive byte.
    step(); req(1'b1, 1'b0, 2'b00, 1'b1, 32'h011, 32'h0); bus(1'b1, 1'b0, 32'h0); #1;
    check("lb1_be", {28'b0, data_be_o}, 32'h2);
    step(); bus(1'b0, 1'b1, 32'h11227F33); #1;
    check("lb1_rdata", rdata_o, 32'h0000007F);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0);

    // Signed half load at offset 0, negative half.
    step(); req(1'b1, 1'b0, 2'b01, 1'b1, 32'h020, 32'h0); bus(1'b1, 1'b0, 32'h0); #1;
    check("lhs_be", {28'b0, data_be_o}, 32'h3);
    step(); bus(1'b0, 1'b1, 32'h12348001); #1;
    check("lhs_rdata", rdata_o, 32'hFFFF8001);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0);

    // Byte store at 0x001.
    step(); req(1'b1, 1'b1, 2'b00, 1'b0, 32'h001, 32'h000000A5); bus(1'b1, 1'b0, 32'h0); #1;
    check("sbst_be",    {28'b0, data_be_o}, 32'h2);
    check("sbst_wdata", data_wdata_o, 32'hA5A5A5A5);
    check("sbst_we",    {31'b0, data_we_o}, 32'd1);
    step(); bus(1'b0, 1'b1, 32'h0); #1;
    check("sbst_done", {31'b0, lsu_done_o}, 32'd1);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0);

    // Half store at offset 2.
    step(); req(1'b1, 1'b1, 2'b01, 1'b0, 32'h0A2, 32'hFFFF1357); bus(1'b1, 1'b0, 32'h0); #1;
    check("shst_be",    {28'b0, data_be_o}, 32'hC);
    check("shst_wdata", data_wdata_o, 32'h13571357);
    step(); bus(1'b0, 1'b1, 32'h0);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0);

    // Word load with grant delayed 3 cycles; enable drops while waiting.
    step(); req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40C, 32'hDEADBEEF); bus(1'b0, 1'b0, 32'h0); #1;
    check("dg_req0",  {31'b0, data_req_o}, 32'd1);
    check("dg_addr0", data_addr_o, 32'h40C);
    check("dg_be0",   {28'b0, data_be_o}, 32'hF);
    step(); #1;
    check("dg_req1",  {31'b0, data_req_o}, 32'd1);
    check("dg_addr1", data_addr_o, 32'h40C);
    step(); req(1'b0, 1'b1, 2'b00, 1'b0, 32'h777, 32'h0); #1;
    check("dg_req2",  {31'b0, data_req_o}, 32'd1);
    check("dg_addr2", data_addr_o, 32'h40C);
    check("dg_we2",   {31'b0, data_we_o}, 32'd0);
    check("dg_be2",   {28'b0, data_be_o}, 32'hF);
    step(); bus(1'b1, 1'b0, 32'h0); #1;
    check("dg_req3",  {31'b0, data_req_o}, 32'd1);
    check("dg_addr3", data_addr_o, 32'h40C);
    check("dg_done3", {31'b0, lsu_done_o}, 32'd0);
    step(); bus(1'b0, 1'b0, 32'h0); #1;
    check("dg_req4",  {31'b0, data_req_o}, 32'd0);
    check("dg_done4", {31'b0, lsu_done_o}, 32'd0);
    step(); bus(1'b0, 1'b1, 32'h12345678); #1;
    check("dg_done5",  {31'b0, lsu_done_o}, 32'd1);
    check("dg_rdata5", rdata_o, 32'h12345678);
    step(); bus(1'b0, 1'b0, 32'h0); #1;
    check("dg_req6",  {31'b0, data_req_o}, 32'd0);
    check("dg_done6", {31'b0, lsu_done_o}, 32'd0);

    // Misaligned word at 0x006 and illegal size.
    step(); req(1'b1, 1'b0, 2'b10, 1'b0, 32'h006, 32'h0); bus(1'b1, 1'b0, 32'h0); #1;
    check("mis_err",  {31'b0, lsu_err_o},  32'd1);
    check("mis_req",  {31'b0, data_req_o}, 32'd0);
    step(); bus(1'b0, 1'b1, 32'hFFFFFFFF); #1;
    check("mis_done", {31'b0, lsu_done_o}, 32'd0);
    check("mis_err_hold", {31'b0, lsu_err_o}, 32'd1);
    step(); req(1'b1, 1'b0, 2'b01, 1'b0, 32'h003, 32'h0); bus(1'b0, 1'b0, 32'h0); #1;
    check("mish_err", {31'b0, lsu_err_o}, 32'd1);
    step(); req(1'b1, 1'b0, 2'b11, 1'b0, 32'h000, 32'h0); #1;
    check("ill_err", {31'b0, lsu_err_o},  32'd1);
    check("ill_req", {31'b0, data_req_o}, 32'd0);
    step(); lsu_en_i = 1'b0; #1;
    check("err_idle", {31'b0, lsu_err_o}, 32'd0);

    // Back-to-back word loads with enable held high.
    step(); req(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0); bus(1'b1, 1'b0, 32'h0); #1;
    check("bb_req0", {31'b0, data_req_o}, 32'd1);
    step(); bus(1'b0, 1'b1, 32'hAAAA5555); #1;
    check("bb_done1",  {31'b0, lsu_done_o}, 32'd1);
    check("bb_rdata1", rdata_o, 32'hAAAA5555);
    check("bb_req1",   {31'b0, data_req_o}, 32'd0);
    step(); addr_i = 32'h304; bus(1'b1, 1'b0, 32'h0); #1;
    check("bb_req2",  {31'b0, data_req_o}, 32'd1);
    check("bb_addr2", data_addr_o, 32'h304);
    check("bb_done2", {31'b0, lsu_done_o}, 32'd0);
    step(); bus(1'b0, 1'b1, 32'h11112222); #1;
    check("bb_done3",  {31'b0, lsu_done_o}, 32'd1);
    check("bb_rdata3", rdata_o, 32'h11112222);
    step(); lsu_en_i = 1'b0; bus(1'b0, 1'b0, 32'h0); #1;
    check("bb_done4", {31'b0, lsu_done_o}, 32'd0);
    check("bb_req4",  {31'b0, data_req_o}, 32'd0);

    // Reset in the middle of a transaction; late rvalid is ignored.
    step(); req(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0); bus(1'b1, 1'b0, 32'h0);
    step(); bus(1'b0, 1'b0, 32'h0); rst_n = 1'b0; #1;
    check("mr_req",  {31'b0, data_req_o}, 32'd0);
    check("mr_done", {31'b0, lsu_done_o}, 32'd0);
    step(); lsu_en_i = 1'b0; rst_n = 1'b1;
    step(); bus(1'b0, 1'b1, 32'hCAFEF00D); #1;
    check("mr_late_done",  {31'b0, lsu_done_o}, 32'd0);
    check("mr_late_rdata", rdata_o, 32'h0);
    step(); bus(1'b0, 1'b0, 32'h0); #1;
    check("mr_idle_req", {31'b0, data_req_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
